enclave_top: RTL and testbench
==============================

Name: enclave_top

Overview:
- Caravel-style user-project top for a small LWE homomorphic-encryption accelerator.
- Wishbone slave exposes a word-addressed ciphertext scratch memory and an opcode register.
- Writing an opcode launches an element-wise operation over two (DIMENSION+1)-element ciphertext vectors in memory.
- The result vector is written back to memory.

Parameters:
- PLAINTEXT_MODULUS, 64, plaintext modulus (informational, no datapath effect)
- PLAINTEXT_WIDTH, 6, log2 of PLAINTEXT_MODULUS (informational)
- CIPHERTEXT_MODULUS, 1024, ciphertext modulus q (power of two)
- CIPHERTEXT_WIDTH, 10, log2(q); arithmetic width
- DIMENSION, 2, LWE dimension n; vector length is DIMENSION+1
- BIG_N, 30, sample count (informational)
- OPCODE_ADDR, 32'h30000000, Wishbone address of opcode register
- OUTPUT_ADDR, 32'h10000000, Wishbone address of status register
- DATA_WIDTH, 128, memory word width
- ADDR_WIDTH, 10, memory index width
- DEPTH, 1024, memory words
- DIM_WIDTH, 4, element-counter width

Ports:
- wb_clk_i in 1: clock, rising edge
- wb_rst_i in 1: asynchronous active-low reset
- wbs_stb_i in 1: strobe
- wbs_cyc_i in 1: cycle
- wbs_we_i in 1: write enable
- wbs_sel_i in 4: byte select (ignored; full-word access)
- wbs_dat_i in 32: write data
- wbs_adr_i in 32: address
- wbs_ack_o out 1: acknowledge
- wbs_dat_o out 32: read data
- la_data_in in 128: unused
- la_data_out out 128: {127'b0, busy}
- la_oenb in 128: unused
- io_in in 38: unused
- io_out out 38: all 0
- io_oeb out 38: all 1 (inputs)
- analog_io inout 29: unconnected
- user_clock2 in 1: unused
- user_irq out 3: bit0 done pulse (see feature), others 0

Behaviour:
- Reset (wb_rst_i=0, async): ack=0, dat_o=0, busy=0, engine IDLE, irq=0. Memory contents are not cleared.
- Decode on stb&cyc:
  - adr==OPCODE_ADDR: opcode register.
  - adr==OUTPUT_ADDR: status register.
  - Otherwise: memory word adr[ADDR_WIDTH-1:0], word-indexed, no byte shift.
- Handshake:
  - ack asserts one cycle after stb&cyc while ack=0 and engine not busy.
  - ack is a single-cycle pulse. A held request re-acks every other cycle; repeated writes are idempotent.
  - While busy, memory/opcode requests are not acked (stall). Status reads are always acked.
- Memory write: word <= zero-extended wbs_dat_i.
- Memory read: dat_o <= word[31:0], registered with ack. dat_o holds until the next ack.
- Status read: dat_o = {30'b0, done_sticky, busy}. done_sticky is cleared on opcode write.
- Opcode word fields:
  - [1:0] op
  - [ADDR_WIDTH+1:2] src0
  - [2*ADDR_WIDTH+1:ADDR_WIDTH+2] src1
  - [3*ADDR_WIDTH+1:2*ADDR_WIDTH+2] dst
- Ops:
  - 00 NOP: no engine start.
  - 01 COPY: dst[i]=src0[i].
  - 10 ADD: dst[i]=(src0[i]+src1[i]) mod q.
  - 11 SUB: dst[i]=(src0[i]-src1[i]) mod q.
- Arithmetic uses bits [CIPHERTEXT_WIDTH-1:0] of each word; results are zero-extended to DATA_WIDTH.
- Engine FSM:
  - IDLE to READ on acked opcode write with op!=00. i=0, busy=1.
  - READ: fetch src0+i and src1+i.
  - WRITE: store dst+i. If i==DIMENSION go to DONE, else i++ and return to READ.
  - DONE: busy=0, done_sticky=1, irq pulse; then IDLE.
- Latency: 2*(DIMENSION+1)+1 cycles from opcode ack to busy low (7 at defaults).
- Address wrap: src/dst+i wraps modulo DEPTH.
- Overlapping dst/src is legal; each element is read before it is written.
- Reset mid-operation aborts the op. Partially written results remain.

Optional Feature:
- Macro ENCLAVE_IRQ_EN.
- Defined: user_irq[0] pulses high for one cycle in DONE.
- Undefined: user_irq is tied to 0; completion is visible only via status/la_data_out.

Test Plan:
- Write mem[0..2]=10,15,20 and mem[100..102]=20,25,30; write opcode op=10,src0=0,src1=100,dst=50; wait 10 cycles; read 50,51,52 -> 30,40,50.
- ADD wrap: mem[3]=1000, mem[103]=30, plus two more element pairs; ADD src0=3,src1=103,dst=60 -> mem[60]=6.
- SUB: src0 element 5, src1 element 9 -> (5-9) mod 1024 = 1020. COPY src0=0,dst=200 -> 10,15,20.
- Status: after the opcode write, reading OUTPUT_ADDR returns busy=1; after 7 cycles it returns 2 (done_sticky=1). A memory read issued while busy is acked only after completion.
- Async reset asserted mid-operation: busy and ack go 0 immediately; the engine is idle after release; a NOP opcode write leaves memory unchanged.
- With ENCLAVE_IRQ_EN defined: exactly one user_irq[0] pulse per completed op. Undefined: user_irq stays 0.

Source files
------------

// File: rtl/enclave_top.sv
// Caravel-style user project: Wishbone-mapped scratch memory plus an element-wise LWE
// ciphertext engine (COPY/ADD/SUB mod q). Optional macro ENCLAVE_IRQ_EN drives user_irq[0].
module enclave_top #(
    parameter int unsigned PLAINTEXT_MODULUS  = 64,
    parameter int unsigned PLAINTEXT_WIDTH    = 6,
    parameter int unsigned CIPHERTEXT_MODULUS = 1024,
    parameter int unsigned CIPHERTEXT_WIDTH   = 10,
    parameter int unsigned DIMENSION          = 2,
    parameter int unsigned BIG_N              = 30,
    parameter logic [31:0] OPCODE_ADDR        = 32'h3000_0000,
    parameter logic [31:0] OUTPUT_ADDR        = 32'h1000_0000,
    parameter int unsigned DATA_WIDTH         = 128,
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned DEPTH              = 1024,
    parameter int unsigned DIM_WIDTH          = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [31:0]  wbs_adr_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    input  logic [127:0] la_oenb,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    inout  wire  [28:0]  analog_io,
    input  logic         user_clock2,
    output logic [2:0]   user_irq
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_COPY = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_SUB  = 2'd3;

    localparam int unsigned CW = CIPHERTEXT_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [1:0]            r_state;
    logic [DIM_WIDTH-1:0]  r_idx;
    logic [31:0]           r_opcode;
    logic [CW-1:0]         r_a;
    logic [CW-1:0]         r_b;
    logic                  r_done;
    logic                  r_ack;
    logic [31:0]           r_dat;

    logic                  w_req;
    logic                  w_busy;
    logic                  w_is_op;
    logic                  w_is_stat;
    logic                  w_accept;
    logic                  w_mem_we;
    logic                  w_op_we;
    logic [ADDR_WIDTH-1:0] w_mem_idx;
    logic [1:0]            w_op;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_src0_idx;
    logic [ADDR_WIDTH-1:0] w_src1_idx;
    logic [ADDR_WIDTH-1:0] w_dst_idx;
    logic [CW-1:0]         w_result;
    logic                  w_unused;

    assign w_req     = wbs_stb_i & wbs_cyc_i;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_is_op   = (wbs_adr_i == OPCODE_ADDR);
    assign w_is_stat = (wbs_adr_i == OUTPUT_ADDR);
    // Status stays reachable while busy so software can poll for completion.
    assign w_accept  = w_req & ~r_ack & (~w_busy | w_is_stat);
    assign w_mem_we  = w_accept & wbs_we_i & ~w_is_op & ~w_is_stat;
    assign w_op_we   = w_accept & wbs_we_i & w_is_op;
    assign w_mem_idx = wbs_adr_i[ADDR_WIDTH-1:0];

    assign w_op       = r_opcode[1:0];
    assign w_off      = ADDR_WIDTH'(r_idx);
    assign w_src0_idx = r_opcode[ADDR_WIDTH+1:2] + w_off;
    assign w_src1_idx = r_opcode[2*ADDR_WIDTH+1:ADDR_WIDTH+2] + w_off;
    assign w_dst_idx  = r_opcode[3*ADDR_WIDTH+1:2*ADDR_WIDTH+2] + w_off;

    // Truncation to CW bits gives the mod-q wrap for free since q is a power of two.
    always_comb begin
        w_result = r_a;
        case (w_op)
            OP_COPY: w_result = r_a;
            OP_ADD:  w_result = r_a + r_b;
            OP_SUB:  w_result = r_a - r_b;
            default: w_result = r_a;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_opcode <= 32'd0;
        end else begin
            r_ack <= w_accept;
            if (w_accept && !wbs_we_i) begin
                if (w_is_stat) begin
                    r_dat <= {30'd0, r_done, w_busy};
                end else if (w_is_op) begin
                    r_dat <= r_opcode;
                end else begin
                    r_dat <= r_mem[w_mem_idx][31:0];
                end
            end
            if (w_op_we) begin
                r_opcode <= wbs_dat_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_op_we) begin
                r_done <= 1'b0;
            end else if (r_state == ST_DONE) begin
                r_done <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_op_we && (wbs_dat_i[1:0] != OP_NOP)) begin
                        r_state <= ST_READ;
                        r_idx   <= '0;
                    end
                end
                ST_READ: begin
                    r_a     <= r_mem[w_src0_idx][CW-1:0];
                    r_b     <= r_mem[w_src1_idx][CW-1:0];
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (r_idx == DIM_WIDTH'(DIMENSION)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus writes are only accepted while idle, so they never collide with engine writes.
    always_ff @(posedge wb_clk_i) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= DATA_WIDTH'(wbs_dat_i);
        end else if (r_state == ST_WRITE) begin
            r_mem[w_dst_idx] <= DATA_WIDTH'(w_result);
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign la_data_out = {127'd0, w_busy};
    assign io_out      = '0;
    assign io_oeb      = '1;

`ifdef ENCLAVE_IRQ_EN
    assign user_irq = {2'b00, (r_state == ST_DONE)};
`else
    assign user_irq = 3'b000;
`endif

    assign w_unused = ^{la_data_in, la_oenb, io_in, user_clock2, wbs_sel_i, analog_io};

endmodule

// File: tb/tb_enclave_top.sv
// Scoreboard bench for enclave_top: driver pushes expected read data, monitor pops on ack.
module tb_enclave_top;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         stb = 1'b0;
    logic         cyc = 1'b0;
    logic         we = 1'b0;
    logic [3:0]   sel = 4'hf;
    logic [31:0]  dat_i = 32'd0;
    logic [31:0]  adr = 32'd0;
    logic         ack;
    logic [31:0]  dat_o;
    logic [127:0] la_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    wire  [28:0]  analog_io;
    logic [2:0]   irq;

    localparam logic [31:0] OPC = 32'h3000_0000;
    localparam logic [31:0] STA = 32'h1000_0000;

    int n_checks = 0;
    int n_fail = 0;
    int irq_count = 0;
    int irq_hi_bits = 0;
    int ops_done = 0;
    logic [31:0] exp_q[$];

    enclave_top dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_i),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .la_data_in  (128'd0),
        .la_data_out (la_out),
        .la_oenb     ({128{1'b1}}),
        .io_in       (38'd0),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .analog_io   (analog_io),
        .user_clock2 (1'b0),
        .user_irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: one cycle after each ack edge, pop and compare read data; also tally irq pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (irq[0] === 1'b1) irq_count++;
            if (irq[2:1] !== 2'b00) irq_hi_bits++;
            if (ack === 1'b1 && we === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read_ack", 32'd1, 32'd0);
                end else begin
                    check($sformatf("read_0x%0h", adr), dat_o, exp_q.pop_front());
                end
            end
        end
    end

    // Called with the clock low (at a negedge); returns at the negedge that sees the ack.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int cycles);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (ack !== 1'b1 && cycles < 50);
        if (ack !== 1'b1) check("ack_timeout", 32'd0, 32'd1);
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int c;
        xfer(1'b1, a, d, c);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        int c;
        exp_q.push_back(e);
        xfer(1'b0, a, 32'd0, c);
    endtask

    function automatic logic [31:0] mk_op(input logic [1:0] op, input logic [9:0] s0,
                                          input logic [9:0] s1, input logic [9:0] d);
        return {d, s1, s0, op};
    endfunction

    initial begin
        int cnt;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_busy", {31'd0, la_out[0]}, 32'd0);
        check("rst_irq", {29'd0, irq}, 32'd0);
        check("io_oeb", {26'd0, io_oeb[37:32]} ^ io_oeb[31:0], 32'hffff_ffc0);
        check("io_out", io_out[31:0] | {26'd0, io_out[37:32]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD basic, busy latency, sticky done
        wr(0, 10); wr(1, 15); wr(2, 20);
        wr(100, 20); wr(101, 25); wr(102, 30);
        wr(OPC, mk_op(2'd2, 10'd0, 10'd100, 10'd50));
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (la_out[0] === 1'b1 && cnt < 20);
        check("busy_latency", cnt, 7);
        ops_done++;
        rd(STA, 32'd2);
        rd(50, 30); rd(51, 40); rd(52, 50);
        check("la_upper_zero", la_out[127:96] | la_out[95:64] | la_out[63:32] | la_out[31:1],
              32'd0);

        // ADD with mod-q wrap; status read while busy
        wr(3, 1000); wr(4, 500); wr(5, 1023);
        wr(103, 30); wr(104, 600); wr(105, 1);
        wr(OPC, mk_op(2'd2, 10'd3, 10'd103, 10'd60));
        rd(STA, 32'd1);
        repeat (10) @(negedge clk);
        ops_done++;
        rd(60, 6); rd(61, 76); rd(62, 0);

        // SUB; memory read issued while busy stalls until the engine is idle
        wr(6, 5); wr(7, 100); wr(8, 0);
        wr(106, 9); wr(107, 40); wr(108, 1);
        wr(OPC, mk_op(2'd3, 10'd6, 10'd106, 10'd70));
        exp_q.push_back(32'd5);
        xfer(1'b0, 6, 32'd0, cnt);
        check("stall_cycles", cnt, 8);
        check("stall_busy_at_ack", {31'd0, la_out[0]}, 32'd0);
        ops_done++;
        rd(70, 1020); rd(71, 60); rd(72, 1023);

        // COPY
        wr(OPC, mk_op(2'd1, 10'd0, 10'd0, 10'd200));
        repeat (10) @(negedge clk);
        ops_done++;
        rd(200, 10); rd(201, 15); rd(202, 20);

        // In-place ADD: dst overlaps both sources
        wr(OPC, mk_op(2'd2, 10'd50, 10'd50, 10'd50));
        repeat (10) @(negedge clk);
        ops_done++;
        rd(50, 60); rd(51, 80); rd(52, 100);

        // COPY with source index wrapping past DEPTH-1
        wr(1022, 7); wr(1023, 8);
        wr(OPC, mk_op(2'd1, 10'd1022, 10'd0, 10'd300));
        repeat (10) @(negedge clk);
        ops_done++;
        rd(300, 7); rd(301, 8); rd(302, 10);

        // Async reset mid-op, before the first result is written
        wr(400, 1); wr(401, 2); wr(402, 3);
        wr(OPC, mk_op(2'd1, 10'd200, 10'd0, 10'd400));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, la_out[0]}, 32'd0);
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_dat", dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {31'd0, la_out[0]}, 32'd0);
        wr(OPC, mk_op(2'd0, 10'd0, 10'd0, 10'd400));
        @(negedge clk);
        check("nop_no_busy", {31'd0, la_out[0]}, 32'd0);
        rd(400, 1); rd(401, 2); rd(402, 3);
        rd(STA, 32'd0);

        repeat (3) @(negedge clk);
`ifdef ENCLAVE_IRQ_EN
        check("irq_pulses", irq_count, ops_done);
`else
        check("irq_pulses", irq_count, 0);
`endif
        check("irq_upper_bits", irq_hi_bits, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
